// File: rtl/rip_bp_updater_pkg.sv
// Shared types and constants for the 2-bit counter predictor table write side.
package rip_branch_predictor_const;

  localparam int TABLE_DEPTH        = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef logic [TABLE_DEPTH-1:0] bp_index_t;
  typedef logic [1:0]             bp_weight_t;

  localparam bp_weight_t STRONGLY_UNTAKEN = 2'b00;
  localparam bp_weight_t WEAKLY_UNTAKEN   = 2'b01;
  localparam bp_weight_t WEAKLY_TAKEN     = 2'b10;
  localparam bp_weight_t STRONGLY_TAKEN   = 2'b11;

  typedef struct packed {
    bp_index_t index;
    logic      taken;
  } bp_record_t;

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic bp_weight_t bp_next_weight(input bp_weight_t w, input logic taken);
    bp_weight_t r;
    r = w;
    if (taken) begin
      if (w != STRONGLY_TAKEN) r = w + 2'd1;
    end else begin
      if (w != STRONGLY_UNTAKEN) r = w - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rip_bp_updater_fifo.sv
// Small circular FIFO holding resolved-branch records; depth must be a power of two.
module rip_bp_update_fifo #(
  parameter int  DEPTH = 4,
  parameter type rec_t = logic [7:0]
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rec_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rip_bp_updater.sv
// Write side of the 2-bit counter table: initialisation sweep, then a two-stage
// read-modify-write pipeline fed from a record FIFO, with same-index forwarding.
module rip_bp_updater
  import rip_branch_predictor_const::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       res_valid,
  output logic       res_ready,
  input  bp_index_t  res_index,
  input  logic       res_taken,
  output logic       tbl_re,
  output bp_index_t  tbl_raddr,
  input  bp_weight_t tbl_rdata,
  output logic       tbl_we,
  output bp_index_t  tbl_waddr,
  output bp_weight_t tbl_wdata,
  output logic       init_done,
  output logic [0:0] fsm_state
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state;
  logic       sweep_on;
  bp_index_t  init_cnt;

  bp_record_t rec_in;
  bp_record_t rec_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  logic       s1_valid;
  bp_index_t  s1_index;
  logic       s1_taken;
  logic       s1_fwd;
  bp_weight_t s1_fwd_data;
  bp_weight_t s1_old;
  bp_weight_t s1_new;

  assign rec_in    = '{index: res_index, taken: res_taken};
  assign res_ready = !fifo_full;
  assign pop       = (state == ST_RUN) && !fifo_empty;
  assign init_done = (state == ST_RUN);
  assign fsm_state = state;

  rip_bp_update_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (bp_record_t)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (res_valid && res_ready),
    .push_data (rec_in),
    .pop       (pop),
    .head      (rec_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The table returns pre-write data when read and written at the same index
  // in one cycle, so the stage-1 result is carried forward instead.
  assign s1_old = s1_fwd ? s1_fwd_data : tbl_rdata;
  assign s1_new = bp_next_weight(s1_old, s1_taken);

  always_comb begin
    tbl_re    = pop;
    tbl_raddr = pop ? rec_head.index : '0;
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = WEAKLY_UNTAKEN;
    if (state == ST_INIT) begin
      tbl_we    = sweep_on;
      tbl_waddr = init_cnt;
    end else if (s1_valid) begin
      tbl_we    = 1'b1;
      tbl_waddr = s1_index;
      tbl_wdata = s1_new;
    end
  end

  // sweep_on holds off the first init write until one clock after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_INIT;
      sweep_on <= 1'b0;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (!sweep_on) begin
        sweep_on <= 1'b1;
      end else begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == '1) state <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid    <= 1'b0;
      s1_index    <= '0;
      s1_taken    <= 1'b0;
      s1_fwd      <= 1'b0;
      s1_fwd_data <= WEAKLY_UNTAKEN;
    end else begin
      s1_valid <= pop;
      if (pop) begin
        s1_index    <= rec_head.index;
        s1_taken    <= rec_head.taken;
        s1_fwd      <= s1_valid && (s1_index == rec_head.index);
        s1_fwd_data <= s1_new;
      end
    end
  end

endmodule

// File: tb/tb_rip_bp_updater.sv
// Directed bench for rip_bp_updater with a behavioural one-cycle-read counter table.
module tb_rip_bp_updater;
  import rip_branch_predictor_const::*;

  localparam int N_ENT = 1 << TABLE_DEPTH;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       res_valid;
  logic       res_ready;
  bp_index_t  res_index;
  logic       res_taken;
  logic       tbl_re;
  bp_index_t  tbl_raddr;
  bp_weight_t tbl_rdata;
  logic       tbl_we;
  bp_index_t  tbl_waddr;
  bp_weight_t tbl_wdata;
  logic       init_done;
  logic [0:0] fsm_state;

  rip_bp_updater #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_index (res_index),
    .res_taken (res_taken),
    .tbl_re    (tbl_re),
    .tbl_raddr (tbl_raddr),
    .tbl_rdata (tbl_rdata),
    .tbl_we    (tbl_we),
    .tbl_waddr (tbl_waddr),
    .tbl_wdata (tbl_wdata),
    .init_done (init_done),
    .fsm_state (fsm_state)
  );

  // table model: registered read, write lands at the edge
  logic [1:0] mem [N_ENT];
  logic       poke_en = 1'b0;
  bp_index_t  poke_idx = '0;
  logic [1:0] poke_val = '0;

  always @(posedge clk) begin
    if (tbl_re)  tbl_rdata <= mem[tbl_raddr];
    if (tbl_we)  mem[tbl_waddr] <= tbl_wdata;
    if (poke_en) mem[poke_idx] <= poke_val;
  end

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int idx, input logic [1:0] v);
    poke_en  = 1'b1;
    poke_idx = bp_index_t'(idx);
    poke_val = v;
    step();
    poke_en  = 1'b0;
  endtask

  task automatic push1(input int idx, input logic t);
    res_valid = 1'b1;
    res_index = bp_index_t'(idx);
    res_taken = t;
    check("push_ready", res_ready, 1);
    step();
    res_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input int idx, input int data);
    check({tag, "_we"},   tbl_we, 1);
    check({tag, "_addr"}, tbl_waddr, idx);
    check({tag, "_data"}, tbl_wdata, data);
  endtask

  task automatic wait_sweep_start();
    int w;
    w = 0;
    while (!tbl_we && w < 8) begin
      step();
      w++;
    end
    check("sweep_start", tbl_we, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    bp_index_t rec_idx [6];
    logic      rec_tk  [6];
    int        k;
    int        seen;
    int        init_acc;
    int        stale;
    bit        chk_full;
    logic      acc;

    rstn      = 1'b0;
    res_valid = 1'b0;
    res_index = '0;
    res_taken = 1'b0;
    step();
    step();

    // reset values
    check("rst_we",        tbl_we, 0);
    check("rst_re",        tbl_re, 0);
    check("rst_ready",     res_ready, 1);
    check("rst_init_done", init_done, 0);
    check("rst_state",     fsm_state, 0);

    // init sweep
    rstn = 1'b1;
    wait_sweep_start();
    for (int i = 0; i < N_ENT; i++) begin
      check("sweep_we",   tbl_we, 1);
      check("sweep_addr", tbl_waddr, i);
      check("sweep_data", tbl_wdata, 1);
      check("sweep_busy", init_done, 0);
      step();
    end
    check("init_done",    init_done, 1);
    check("post_sweep_we", tbl_we, 0);
    check("run_state",    fsm_state, 1);

    // single update: read at cycle 1, write at cycle 2
    push1(5, 1'b1);
    check("one_re",    tbl_re, 1);
    check("one_raddr", tbl_raddr, 5);
    check("one_no_we", tbl_we, 0);
    step();
    expect_write("one", 5, 2);
    step();
    check("one_idle", tbl_we, 0);

    // saturation at both ends
    poke(3, 2'b11);
    push1(3, 1'b1);
    step();
    expect_write("sat_hi", 3, 3);
    step();
    poke(3, 2'b00);
    push1(3, 1'b0);
    step();
    expect_write("sat_lo", 3, 0);
    step();

    // back-to-back same index, forwarding path
    poke(7, 2'b00);
    res_valid = 1'b1;
    res_index = 7;
    res_taken = 1'b1;
    check("b2b_ready0", res_ready, 1);
    step();
    check("b2b_re", tbl_re, 1);
    check("b2b_ready1", res_ready, 1);
    step();
    expect_write("b2b_1", 7, 1);
    step();
    res_valid = 1'b0;
    expect_write("b2b_2", 7, 2);
    step();
    expect_write("b2b_3", 7, 3);
    step();
    check("b2b_idle", tbl_we, 0);

    // backpressure during init, then in-order drain
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    rec_idx = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd10};
    rec_tk  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_q = {};
    for (int i = 0; i < 6; i++)
      exp_q.push_back({rec_idx[i], rec_tk[i] ? 2'b10 : 2'b00});
    k = 0;
    seen = 0;
    init_acc = 0;
    chk_full = 1'b0;
    for (int cyc = 0; cyc < 200 && seen < 6; cyc++) begin
      res_valid = (k < 6);
      res_index = rec_idx[k < 6 ? k : 5];
      res_taken = rec_tk[k < 6 ? k : 5];
      if (!init_done && k == 4 && !chk_full) begin
        check("full_ready", res_ready, 0);
        chk_full = 1'b1;
      end
      if (init_done && tbl_we) begin
        if (exp_q.size() == 0) check("extra_write", 1, 0);
        else check("drain", {tbl_waddr, tbl_wdata}, exp_q.pop_front());
        seen++;
      end
      acc = res_valid && res_ready;
      if (acc && !init_done) init_acc++;
      step();
      if (acc) k++;
    end
    res_valid = 1'b0;
    check("init_accepts", init_acc, 4);
    check("full_seen", chk_full, 1);
    check("drained", seen, 6);
    check("exp_empty", exp_q.size(), 0);

    // reset mid-sweep with buffered records
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) push1(8 + i, 1'b1);
    step();
    step();
    rstn = 1'b0;
    #1;
    check("midrst_we",    tbl_we, 0);
    check("midrst_ready", res_ready, 1);
    step();
    rstn = 1'b1;
    wait_sweep_start();
    check("resweep_addr", tbl_waddr, 0);
    check("resweep_data", tbl_wdata, 1);
    stale = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (init_done && (tbl_we || tbl_re)) stale++;
      step();
    end
    check("no_stale", stale, 0);
    check("resweep_done", init_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
